riscv_btb_assoc_counter: RTL and testbench

Parametrised N-way set-associative branch target buffer with per-entry saturating direction counters, tag matching, round-robin replacement and a sweep-based invalidate. It is the next-generation table behind the jump-predictor next-PC strategy: fetch PC word addresses are looked up combinationally, and resolved jumps from the history interface train it. It replaces the direct-mapped BTB/counter table when `USE_JUMP_PREDICTOR` is set.

---
 rtl/riscv_btb_assoc_counter.sv | 150 +++++++++++++++
 tb/tb_riscv_btb_assoc_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_btb_assoc_counter.sv
// rtl/riscv_btb_assoc_counter.sv - N-way set-associative BTB with saturating direction counters
// Combinational lookup, trained by resolved jumps, cleared by a set-by-set sweep.
module riscv_btb_assoc_counter #(
  parameter int ADDR_WIDTH    = 62,
  parameter int INDEX_WIDTH   = 4,
  parameter int WAYS          = 2,
  parameter int VALUE_WIDTH   = 62,
  parameter int COUNTER_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   enable,
  input  logic                   i_stall,
  input  logic [ADDR_WIDTH-1:0]  i_read_addr,
  output logic [VALUE_WIDTH-1:0] o_read_value,
  output logic                   o_read_jump,
  output logic                   o_read_valid,
  input  logic [ADDR_WIDTH-1:0]  i_write_addr,
  input  logic [VALUE_WIDTH-1:0] i_write_value,
  input  logic                   i_write_jump,
  input  logic                   i_write_uncond,
  input  logic                   i_write_enable,
  input  logic                   i_invalidate,
  output logic                   o_busy
);
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_WEAK = COUNTER_WIDTH'(1) << (COUNTER_WIDTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state_q, state_d;

  logic [WAYS-1:0]          valid_q [SETS];
  logic [TAG_WIDTH-1:0]     tag_q   [SETS][WAYS];
  logic [VALUE_WIDTH-1:0]   value_q [SETS][WAYS];
  logic [COUNTER_WIDTH-1:0] cnt_q   [SETS][WAYS];
  logic [WAY_W-1:0]         rr_q    [SETS];
  logic [INDEX_WIDTH-1:0]   sweep_idx;

  logic [INDEX_WIDTH-1:0] rd_idx, wr_idx;
  logic [TAG_WIDTH-1:0]   rd_tag, wr_tag;
  logic                   rd_hit, rd_ok, wr_hit, inv_found, wr_acc, do_update, do_alloc, sweep_step;
  logic [WAY_W-1:0]       rd_way, wr_way, inv_way, victim, rr_next;
  logic [COUNTER_WIDTH-1:0] cur_cnt, upd_cnt;

  assign rd_idx = i_read_addr[INDEX_WIDTH-1:0];
  assign rd_tag = i_read_addr[ADDR_WIDTH-1:INDEX_WIDTH];
  assign wr_idx = i_write_addr[INDEX_WIDTH-1:0];
  assign wr_tag = i_write_addr[ADDR_WIDTH-1:INDEX_WIDTH];

  always_comb begin
    rd_hit    = 1'b0;
    rd_way    = '0;
    wr_hit    = 1'b0;
    wr_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[rd_idx][w] && tag_q[rd_idx][w] == rd_tag) begin
        rd_hit = 1'b1;
        rd_way = WAY_W'(w);
      end
      if (valid_q[wr_idx][w] && tag_q[wr_idx][w] == wr_tag) begin
        wr_hit = 1'b1;
        wr_way = WAY_W'(w);
      end
      if (!valid_q[wr_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  // Lookups are suppressed while sweeping so half-cleared sets never predict.
  assign rd_ok        = rd_hit && enable && (state_q == IDLE);
  assign o_read_valid = rd_ok;
  assign o_read_value = rd_ok ? value_q[rd_idx][rd_way] : '0;
  assign o_read_jump  = rd_ok && cnt_q[rd_idx][rd_way][COUNTER_WIDTH-1];
  assign o_busy       = (state_q == SWEEP);

  assign wr_acc    = i_write_enable && enable && !i_stall && (state_q == IDLE) && !i_invalidate;
  assign do_update = wr_acc && wr_hit;
  assign do_alloc  = wr_acc && !wr_hit && (i_write_jump || i_write_uncond);
  assign victim    = inv_found ? inv_way : rr_q[wr_idx];
  assign rr_next   = (rr_q[wr_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[wr_idx] + 1'b1;
  assign cur_cnt   = cnt_q[wr_idx][wr_way];

  always_comb begin
    upd_cnt = cur_cnt;
    if (i_write_uncond)
      upd_cnt = '1;
    else if (i_write_jump)
      upd_cnt = (cur_cnt == '1) ? cur_cnt : cur_cnt + 1'b1;
    else
      upd_cnt = (cur_cnt == '0) ? cur_cnt : cur_cnt - 1'b1;
  end

  // Payload arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (do_update) begin
      cnt_q[wr_idx][wr_way] <= upd_cnt;
      if (i_write_jump || i_write_uncond)
        value_q[wr_idx][wr_way] <= i_write_value;
    end
    if (do_alloc) begin
      tag_q[wr_idx][victim]   <= wr_tag;
      value_q[wr_idx][victim] <= i_write_value;
      cnt_q[wr_idx][victim]   <= i_write_uncond ? '1 : CNT_WEAK;
    end
  end

  assign sweep_step = (state_q == SWEEP) && enable && !i_stall;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && i_invalidate) state_d = SWEEP;
      SWEEP:   if (sweep_step && sweep_idx == INDEX_WIDTH'(SETS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sweep_idx <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (state_q == IDLE && enable && i_invalidate)
        sweep_idx <= '0;
      if (sweep_step) begin
        valid_q[sweep_idx] <= '0;
        rr_q[sweep_idx]    <= '0;
        sweep_idx          <= sweep_idx + 1'b1;
      end
      if (do_alloc) begin
        valid_q[wr_idx][victim] <= 1'b1;
        if (!inv_found) rr_q[wr_idx] <= rr_next;
      end
    end
  end
endmodule

// File: tb/tb_riscv_btb_assoc_counter.sv
// tb/tb_riscv_btb_assoc_counter.sv - scoreboard bench for riscv_btb_assoc_counter
// Stimulus queues expected lookups; a negedge monitor pops and compares.
module tb_riscv_btb_assoc_counter;
  logic        clk = 1'b0;
  logic        nreset, enable, i_stall;
  logic [61:0] i_read_addr, o_read_value, i_write_addr, i_write_value;
  logic        o_read_jump, o_read_valid, o_busy;
  logic        i_write_jump, i_write_uncond, i_write_enable, i_invalidate;

  riscv_btb_assoc_counter dut (
    .clk(clk), .nreset(nreset), .enable(enable), .i_stall(i_stall),
    .i_read_addr(i_read_addr), .o_read_value(o_read_value), .o_read_jump(o_read_jump),
    .o_read_valid(o_read_valid), .i_write_addr(i_write_addr), .i_write_value(i_write_value),
    .i_write_jump(i_write_jump), .i_write_uncond(i_write_uncond),
    .i_write_enable(i_write_enable), .i_invalidate(i_invalidate), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        valid;
    logic        jump;
    logic [61:0] value;
  } exp_t;

  exp_t exp_q[$];
  logic chk = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_busy;

  always @(negedge clk) begin
    if (chk) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL lookup_underflow: got a lookup with no expected entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (o_busy !== e.busy || o_read_valid !== e.valid || o_read_jump !== e.jump ||
            o_read_value !== e.value) begin
          n_fail++;
          $display("FAIL lookup addr=%h: got busy=%b valid=%b jump=%b value=%h, want busy=%b valid=%b jump=%b value=%h",
                   i_read_addr, o_busy, o_read_valid, o_read_jump, o_read_value,
                   e.busy, e.valid, e.jump, e.value);
        end
      end
    end
  end

  task automatic chk_eq(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic rd(input logic [61:0] a, input logic v, input logic j, input logic [61:0] val);
    i_read_addr = a;
    exp_q.push_back('{1'b0, v, j, val});
    chk = 1'b1;
    @(posedge clk); #1;
    chk = 1'b0;
  endtask

  task automatic wr(input logic [61:0] a, input logic [61:0] val, input logic j, input logic u);
    i_write_addr = a; i_write_value = val; i_write_jump = j; i_write_uncond = u;
    i_write_enable = 1'b1;
    @(posedge clk); #1;
    i_write_enable = 1'b0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
  endtask

  task automatic sweep_measure(input int stall_at, output int n);
    n = 0;
    i_read_addr = 62'h101;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (o_busy) n++;
      else break;
      if (n == 1) chk_eq("read_valid_in_sweep", int'(o_read_valid), 0);
      if (n == 4) begin
        i_write_addr = 62'h104; i_write_value = 62'h204; i_write_jump = 1'b1;
        i_write_uncond = 1'b0; i_write_enable = 1'b1;
      end
      if (n == 5) i_write_enable = 1'b0;
      if (stall_at > 0 && n == stall_at) i_stall = 1'b1;
      if (stall_at > 0 && n == stall_at + 3) i_stall = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    enable = 1'b1; i_stall = 1'b0; i_read_addr = '0; i_write_addr = '0; i_write_value = '0;
    i_write_jump = 1'b0; i_write_uncond = 1'b0; i_write_enable = 1'b0; i_invalidate = 1'b0;
    do_reset();

    rd(62'h100, 1'b0, 1'b0, 62'h0);
    chk_eq("busy_after_reset", int'(o_busy), 0);

    // counter training on 0x100: alloc weakly taken (2), then 1, 0, hold 0, back to 1
    wr(62'h100, 62'h200, 1'b1, 1'b0);
    rd(62'h100, 1'b1, 1'b1, 62'h200);
    enable = 1'b0;
    rd(62'h100, 1'b0, 1'b0, 62'h0);
    enable = 1'b1;
    wr(62'h100, 62'h999, 1'b0, 1'b0);
    rd(62'h100, 1'b1, 1'b0, 62'h200);
    wr(62'h100, 62'h999, 1'b0, 1'b0);
    wr(62'h100, 62'h999, 1'b0, 1'b0);
    rd(62'h100, 1'b1, 1'b0, 62'h200);
    wr(62'h100, 62'h300, 1'b1, 1'b0);
    rd(62'h100, 1'b1, 1'b0, 62'h300);

    // replacement in set 0
    do_reset();
    wr(62'h10, 62'hA1, 1'b1, 1'b0);
    wr(62'h20, 62'hA2, 1'b1, 1'b0);
    wr(62'h30, 62'hA3, 1'b1, 1'b0);
    rd(62'h10, 1'b0, 1'b0, 62'h0);
    rd(62'h20, 1'b1, 1'b1, 62'hA2);
    rd(62'h30, 1'b1, 1'b1, 62'hA3);
    wr(62'h40, 62'hA4, 1'b1, 1'b0);
    rd(62'h20, 1'b0, 1'b0, 62'h0);
    rd(62'h30, 1'b1, 1'b1, 62'hA3);
    rd(62'h40, 1'b1, 1'b1, 62'hA4);

    // unconditional allocation: 3 -> 2 (jump) -> 1 (no jump)
    wr(62'h55, 62'h155, 1'b0, 1'b1);
    rd(62'h55, 1'b1, 1'b1, 62'h155);
    wr(62'h55, 62'h0, 1'b0, 1'b0);
    rd(62'h55, 1'b1, 1'b1, 62'h155);
    wr(62'h55, 62'h0, 1'b0, 1'b0);
    rd(62'h55, 1'b1, 1'b0, 62'h155);

    // same-cycle read and write of 0x77
    do_reset();
    i_write_addr = 62'h77; i_write_value = 62'h177; i_write_jump = 1'b1;
    i_write_uncond = 1'b0; i_write_enable = 1'b1;
    rd(62'h77, 1'b0, 1'b0, 62'h0);
    i_write_enable = 1'b0;
    rd(62'h77, 1'b1, 1'b1, 62'h177);

    // invalidate sweep
    wr(62'h101, 62'h201, 1'b1, 1'b0);
    wr(62'h102, 62'h202, 1'b1, 1'b0);
    wr(62'h103, 62'h203, 1'b1, 1'b0);
    rd(62'h102, 1'b1, 1'b1, 62'h202);
    i_invalidate = 1'b1;
    @(posedge clk); #1;
    i_invalidate = 1'b0;
    sweep_measure(0, n_busy);
    chk_eq("sweep_busy_cycles", n_busy, 16);
    rd(62'h101, 1'b0, 1'b0, 62'h0);
    rd(62'h102, 1'b0, 1'b0, 62'h0);
    rd(62'h103, 1'b0, 1'b0, 62'h0);
    rd(62'h104, 1'b0, 1'b0, 62'h0);
    rd(62'h77, 1'b0, 1'b0, 62'h0);

    // stalled sweep
    wr(62'h105, 62'h205, 1'b1, 1'b0);
    rd(62'h105, 1'b1, 1'b1, 62'h205);
    i_invalidate = 1'b1;
    @(posedge clk); #1;
    i_invalidate = 1'b0;
    sweep_measure(5, n_busy);
    chk_eq("stalled_sweep_busy_cycles", n_busy, 19);
    rd(62'h105, 1'b0, 1'b0, 62'h0);
    rd(62'h104, 1'b0, 1'b0, 62'h0);

    @(posedge clk); #1;
    chk_eq("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
